// File: rtl/io_bus_request_port.sv
// io_bus_request_port: fast-clock-side master of the I/O bus slave port.
// Turns CPU I/O accesses into the IOREQ/IOWE/IOLDS/IOUDS level handshake for
// the PDS bus master. IOACT/IOBERR arrive from another clock domain and are
// synchronized here. ACK or BERR goes back to the CPU.
// Optional feature: define POSTED_WRITE_EN to acknowledge writes at accept
// time and report their errors later on WBERR.
module io_bus_request_port #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic CLK,
    input  logic RES,
    input  logic CPUREQ,
    input  logic CPUWE,
    input  logic CPULDS,
    input  logic CPUUDS,
    output logic CPUACK,
    output logic CPUBERR,
    output logic ALE1,
    output logic IOREQ,
    output logic IOWE,
    output logic IOLDS,
    output logic IOUDS,
    input  logic IOACT,
    input  logic IOBERR,
    output logic BUSY,
    output logic WBERR
);

`ifdef POSTED_WRITE_EN
    localparam logic POSTED_EN = 1'b1;
`else
    localparam logic POSTED_EN = 1'b0;
`endif

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, ACT, DONE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] act_sync, berr_sync;
    logic       io_act_s, io_berr_s;
    logic       arm_q, arm_d;
    logic [7:0] cnt_q, cnt_d;
    logic       tout_q, tout_d;
    logic       act_low_q, act_low_d;
    logic       berrf_q, berrf_d;
    logic       posted_q, posted_d;
    logic       req_d, we_d, lds_d, uds_d, ale_d, ack_d, berr_d, wberr_d;

    assign io_act_s  = act_sync[SYNC_STAGES-1];
    assign io_berr_s = berr_sync[SYNC_STAGES-1];
    assign BUSY      = (state_q != IDLE);

    // Bring IOACT/IOBERR into the CLK domain through shift-register synchronizers.
    // NOTE: the synchronizer flops are reset so IOACTs reads 0 until IOACT really rises.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            act_sync  <= '0;
            berr_sync <= '0;
        end else begin
            act_sync  <= {act_sync[SYNC_STAGES-2:0], IOACT};
            berr_sync <= {berr_sync[SYNC_STAGES-2:0], IOBERR};
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state, bookkeeping and registered-output values.
    // NOTE: every target gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        arm_d     = arm_q;
        cnt_d     = cnt_q;
        tout_d    = tout_q;
        act_low_d = act_low_q;
        berrf_d   = berrf_q;
        posted_d  = posted_q;
        req_d     = IOREQ;
        we_d      = IOWE;
        lds_d     = IOLDS;
        uds_d     = IOUDS;
        ale_d     = 1'b0;
        ack_d     = 1'b0;
        berr_d    = 1'b0;
        wberr_d   = 1'b0;

        if (!CPUREQ) arm_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (CPUREQ && arm_q) begin
                    state_d  = REQ;
                    req_d    = 1'b1;
                    ale_d    = 1'b1;
                    we_d     = CPUWE;
                    lds_d    = CPULDS;
                    uds_d    = CPUUDS;
                    cnt_d    = '0;
                    tout_d   = 1'b0;
                    posted_d = POSTED_EN & CPUWE;
                    // A posted write is released to the CPU right away.
                    if (POSTED_EN && CPUWE) ack_d = 1'b1;
                end
            end
            REQ: begin
                cnt_d     = cnt_q + 8'd1;
                act_low_d = 1'b0;
                if (io_act_s) begin
                    req_d   = 1'b0;
                    state_d = ACT;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    req_d   = 1'b0;
                    tout_d  = 1'b1;
                    state_d = ACT;
                end
            end
            ACT: begin
                // Two consecutive low samples; a late IOACT after timeout restarts the filter.
                if (io_act_s) begin
                    act_low_d = 1'b0;
                end else if (act_low_q) begin
                    state_d = DONE;
                    berrf_d = io_berr_s | tout_q;
                end else begin
                    act_low_d = 1'b1;
                end
            end
            DONE: begin
                if (posted_q) begin
                    wberr_d = berrf_q;
                end else begin
                    ack_d  = 1'b1;
                    berr_d = berrf_q;
                end
                tout_d   = 1'b0;
                posted_d = 1'b0;
                we_d     = 1'b0;
                lds_d    = 1'b0;
                uds_d    = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every acknowledge disarms until the CPU is seen to drop its request.
        if (ack_d) arm_d = 1'b0;
    end

    // Registered outputs and access bookkeeping.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            arm_q     <= 1'b1;
            cnt_q     <= '0;
            tout_q    <= 1'b0;
            act_low_q <= 1'b0;
            berrf_q   <= 1'b0;
            posted_q  <= 1'b0;
            IOREQ     <= 1'b0;
            IOWE      <= 1'b0;
            IOLDS     <= 1'b0;
            IOUDS     <= 1'b0;
            ALE1      <= 1'b0;
            CPUACK    <= 1'b0;
            CPUBERR   <= 1'b0;
            WBERR     <= 1'b0;
        end else begin
            arm_q     <= arm_d;
            cnt_q     <= cnt_d;
            tout_q    <= tout_d;
            act_low_q <= act_low_d;
            berrf_q   <= berrf_d;
            posted_q  <= posted_d;
            IOREQ     <= req_d;
            IOWE      <= we_d;
            IOLDS     <= lds_d;
            IOUDS     <= uds_d;
            ALE1      <= ale_d;
            CPUACK    <= ack_d;
            CPUBERR   <= berr_d;
            WBERR     <= wberr_d;
        end
    end

endmodule

// File: tb/tb_io_bus_request_port.sv
// Directed self-checking bench for io_bus_request_port (TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_io_bus_request_port;

    logic CLK = 1'b0;
    logic RES, CPUREQ, CPUWE, CPULDS, CPUUDS, IOACT, IOBERR;
    logic CPUACK, CPUBERR, ALE1, IOREQ, IOWE, IOLDS, IOUDS, BUSY, WBERR;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int SIG_IOREQ = 0;
    localparam int SIG_ACK   = 1;

    io_bus_request_port #(.SYNC_STAGES(2), .TIMEOUT(16)) dut (
        .CLK(CLK), .RES(RES),
        .CPUREQ(CPUREQ), .CPUWE(CPUWE), .CPULDS(CPULDS), .CPUUDS(CPUUDS),
        .CPUACK(CPUACK), .CPUBERR(CPUBERR), .ALE1(ALE1),
        .IOREQ(IOREQ), .IOWE(IOWE), .IOLDS(IOLDS), .IOUDS(IOUDS),
        .IOACT(IOACT), .IOBERR(IOBERR), .BUSY(BUSY), .WBERR(WBERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic sig(input int sel);
        return (sel == SIG_IOREQ) ? IOREQ : CPUACK;
    endfunction

    // Count falling edges until the selected output reaches lvl; -1 if it never does.
    task automatic wait_level(input int sel, input logic lvl, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (sig(sel) === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    // Non-posted access: IOACT rises 2.5 CLK after IOREQ is seen, held 20 CLK.
    task automatic run_access(input string tag, input logic we, input logic lds,
                              input logic uds, input logic berr, input logic drop);
        int n;
        CPUREQ = 1'b1; CPUWE = we; CPULDS = lds; CPUUDS = uds;
        @(negedge CLK);
        check({tag, "_ioreq"}, IOREQ, 1);
        check({tag, "_ale1"}, ALE1, 1);
        check({tag, "_strobes"}, {IOWE, IOLDS, IOUDS}, {we, lds, uds});
        check({tag, "_early_ack"}, CPUACK, 0);
        @(negedge CLK);
        check({tag, "_ale1_pulse"}, ALE1, 0);
        @(negedge CLK);
        IOACT = 1'b1;
        wait_level(SIG_IOREQ, 1'b0, n);
        check({tag, "_ioreq_drop"}, n, 3);
        repeat (17) @(negedge CLK);
        IOACT = 1'b0; IOBERR = berr;
        wait_level(SIG_ACK, 1'b1, n);
        check({tag, "_ack_lat"}, n, 5);
        check({tag, "_berr"}, CPUBERR, berr);
        check({tag, "_busy_done"}, BUSY, 0);
        check({tag, "_strobes_rel"}, {IOWE, IOLDS, IOUDS}, 0);
        check({tag, "_wberr"}, WBERR, 0);
        IOBERR = 1'b0;
        if (drop) CPUREQ = 1'b0;
        @(negedge CLK);
        check({tag, "_ack_pulse"}, CPUACK, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        logic held;
        RES = 1'b1; CPUREQ = 1'b0; CPUWE = 1'b0; CPULDS = 1'b0; CPUUDS = 1'b0;
        IOACT = 1'b0; IOBERR = 1'b0;
        @(negedge CLK);
        check("rst_outputs", {CPUACK, CPUBERR, ALE1, IOREQ, IOWE, IOLDS, IOUDS, BUSY, WBERR}, 0);
        RES = 1'b0;
        @(negedge CLK);

        run_access("rd", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_access("rd_err", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // IOACT never rises: IOREQ drops after 16 CLK, error ack 3 CLK after that.
        CPUREQ = 1'b1; CPUWE = 1'b0; CPULDS = 1'b1; CPUUDS = 1'b1;
        @(negedge CLK);
        check("to_ioreq", IOREQ, 1);
        wait_level(SIG_IOREQ, 1'b0, n);
        check("to_drop", n, 16);
        wait_level(SIG_ACK, 1'b1, n);
        check("to_ack_lat", n, 3);
        check("to_berr", CPUBERR, 1);
        CPUREQ = 1'b0;
        @(negedge CLK);

`ifdef POSTED_WRITE_EN
        // Posted write with bus error, read queued behind it.
        CPUREQ = 1'b1; CPUWE = 1'b1; CPULDS = 1'b1; CPUUDS = 1'b0;
        @(negedge CLK);
        check("pw_ack", CPUACK, 1);
        check("pw_ack_berr", CPUBERR, 0);
        check("pw_ioreq", IOREQ, 1);
        check("pw_we", IOWE, 1);
        CPUREQ = 1'b0;
        @(negedge CLK);
        CPUREQ = 1'b1; CPUWE = 1'b0; CPULDS = 1'b1; CPUUDS = 1'b1;
        @(negedge CLK);
        IOACT = 1'b1;
        held = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            if (CPUACK || ALE1) held = 1'b0;
        end
        IOACT = 1'b0; IOBERR = 1'b1;
        repeat (4) begin
            @(negedge CLK);
            if (CPUACK || ALE1) held = 1'b0;
        end
        check("pw_read_held", held, 1);
        @(negedge CLK);
        check("pw_wberr", WBERR, 1);
        check("pw_no_ack", CPUACK, 0);
        check("pw_busy", BUSY, 0);
        check("pw_strobes_rel", {IOWE, IOLDS, IOUDS}, 0);
        IOBERR = 1'b0;
        run_access("pw_rd", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
`else
        run_access("wr", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
`endif

        // CPUREQ held past CPUACK: no second accept until it is seen low.
        run_access("arm_rd", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        held = 1'b1;
        repeat (5) begin
            if (IOREQ || ALE1 || BUSY) held = 1'b0;
            @(negedge CLK);
        end
        check("arm_hold", held, 1);
        CPUREQ = 1'b0;
        @(negedge CLK);
        run_access("arm_rd2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset while in ACT.
        CPUREQ = 1'b1; CPUWE = 1'b0; CPULDS = 1'b1; CPUUDS = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        IOACT = 1'b1;
        wait_level(SIG_IOREQ, 1'b0, n);
        check("ract_drop", n, 3);
        @(negedge CLK);
        check("ract_busy", BUSY, 1);
        #1 RES = 1'b1;
        #1;
        check("ract_rst", {IOREQ, ALE1, CPUACK, BUSY, IOWE, IOLDS, IOUDS}, 0);
        CPUREQ = 1'b0; IOACT = 1'b0;
        @(negedge CLK);
        RES = 1'b0;
        @(negedge CLK);

        // Reset while IOREQ is high: it must drop without waiting for a clock.
        CPUREQ = 1'b1;
        @(negedge CLK);
        check("rreq_ioreq", IOREQ, 1);
        #1 RES = 1'b1;
        #1;
        check("rreq_rst", {IOREQ, ALE1, BUSY}, 0);
        CPUREQ = 1'b0;
        @(negedge CLK);
        RES = 1'b0;
        @(negedge CLK);

        run_access("post_rst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
